clock_monitor: RTL and testbench

- Measures the divided CPU clock produced by the clock generator from the receiving side.
- Samples the monitored clock in the `clk` domain and measures its period in `clk` cycles.
- Reports lock when the period is stable, and flags a stall when edges stop arriving.
- Used for bring-up and debug: drives LEDs and a debug register read by the CPU.

---
 rtl/clock_monitor.sv | 178 +++++++++++++++++
 tb/tb_clock_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Measures the period of an asynchronous monitored clock in clk cycles, reporting lock and stall.
// Optional high-phase measurement is enabled with the CLK_MON_HIGH_TIME_EN macro.
module clock_monitor #(
  parameter int CNT_W   = 21,
  parameter int TIMEOUT = 1000000,
  parameter int TOL     = 1,
  parameter int LOCK_N  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stall,
  output logic [15:0]      edge_cnt,
  output logic [CNT_W-1:0] high_time,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2, STALLED = 2'd3} state_e;

  localparam int               ST_W      = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [ST_W-1:0]  LOCK_C    = ST_W'(LOCK_N);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, per_prev_q, per_prev_d;
  logic             pv_q, pv_d, locked_q, locked_d, stall_q, stall_d, first_q, first_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [15:0]      edge_q, edge_d;
  logic             rise;
  logic [CNT_W:0]   diff;
  logic             in_tol;

  always_comb begin
    sync1_d    = mon_clk;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rise       = sync2_q & ~prev_q;
    // Magnitude at CNT_W+1 bits so the subtraction never wraps.
    diff       = (cnt_q >= per_prev_q) ? ({1'b0, cnt_q} - {1'b0, per_prev_q})
                                       : ({1'b0, per_prev_q} - {1'b0, cnt_q});
    in_tol     = (diff <= TOL_C);
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    per_prev_d = per_prev_q;
    pv_d       = 1'b0;
    locked_d   = locked_q;
    stall_d    = stall_q;
    stable_d   = stable_q;
    first_d    = first_q;
    edge_d     = rise ? edge_q + 16'd1 : edge_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          first_d = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          cnt_d      = {{(CNT_W-1){1'b0}}, 1'b1};
          period_d   = cnt_q;
          per_prev_d = cnt_q;
          pv_d       = 1'b1;
          if (first_q) begin
            first_d  = 1'b0;
            stable_d = '0;
          end else if (in_tol) begin
            stable_d = (stable_q == LOCK_C) ? stable_q : stable_q + 1'b1;
          end else begin
            stable_d = '0;
          end
          if (state_q == MEASURE && stable_d == LOCK_C) begin
            locked_d = 1'b1;
            state_d  = LOCKED;
          end else if (state_q == LOCKED && !in_tol) begin
            locked_d = 1'b0;
            state_d  = MEASURE;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          stall_d  = 1'b1;
          locked_d = 1'b0;
          stable_d = '0;
          state_d  = STALLED;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      STALLED: begin
        // The partial period ending at this edge is discarded.
        if (rise) begin
          stall_d = 1'b0;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          first_d = 1'b1;
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      per_prev_q <= '0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      stall_q    <= 1'b0;
      stable_q   <= '0;
      first_q    <= 1'b0;
      edge_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      per_prev_q <= per_prev_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      stall_q    <= stall_d;
      stable_q   <= stable_d;
      first_q    <= first_d;
      edge_q     <= edge_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign stall        = stall_q;
  assign edge_cnt     = edge_q;
  assign state_dbg    = state_q;

`ifdef CLK_MON_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hlat_q, hlat_d, high_q, high_d;
  logic             fall;

  // High phase is latched on the falling edge, published with the next period.
  always_comb begin
    fall   = ~sync2_q & prev_q;
    hcnt_d = hcnt_q;
    if (rise) hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (sync2_q && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
    hlat_d = fall ? hcnt_q : hlat_q;
    high_d = high_q;
    if (rise && (state_q == MEASURE || state_q == LOCKED)) high_d = hlat_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      hlat_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      hlat_q <= hlat_d;
      high_q <= high_d;
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif
endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (wide counter with TIMEOUT=100, 4-bit counter with TIMEOUT=15).
module tb_clock_monitor;
  localparam int CW_A = 21;
  localparam int CW_B = 4;

`ifdef CLK_MON_HIGH_TIME_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mon_a = 1'b0, mon_b = 1'b0;
  logic [CW_A-1:0] per_a, ht_a;
  logic            pv_a, lk_a, st_a;
  logic [15:0]     ec_a;
  logic [1:0]      sd_a;
  logic [CW_B-1:0] per_b, ht_b;
  logic            pv_b, lk_b, st_b;
  logic [15:0]     ec_b;
  logic [1:0]      sd_b;

  int vectors = 0;
  int miscompares = 0;
  logic [CW_A-1:0] exp_a_q[$];
  logic [CW_B-1:0] exp_b_q[$];
  logic [CW_A-1:0] exp_a_e;
  logic [CW_B-1:0] exp_b_e;
  bit armed_a = 1'b0, armed_b = 1'b0;
  int last_a = 0, last_b = 0;
  bit watch_b = 1'b0;
  int stall_seen_b = 0;

  clock_monitor #(.CNT_W(CW_A), .TIMEOUT(100), .TOL(1), .LOCK_N(4)) dut_a (
    .clk(clk), .rst(rst), .mon_clk(mon_a), .period(per_a), .period_valid(pv_a),
    .locked(lk_a), .stall(st_a), .edge_cnt(ec_a), .high_time(ht_a), .state_dbg(sd_a)
  );

  clock_monitor #(.CNT_W(CW_B), .TIMEOUT(15), .TOL(1), .LOCK_N(4)) dut_b (
    .clk(clk), .rst(rst), .mon_clk(mon_b), .period(per_b), .period_valid(pv_b),
    .locked(lk_b), .stall(st_b), .edge_cnt(ec_b), .high_time(ht_b), .state_dbg(sd_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every period_valid pops one expected period
  always @(negedge clk) begin
    if (pv_a) begin
      vectors++;
      if (exp_a_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_a: period_valid with period=%0d, no period expected", per_a);
      end else begin
        exp_a_e = exp_a_q.pop_front();
        if (per_a !== exp_a_e) begin
          miscompares++;
          $display("FAIL sb_a: period=%0d expected=%0d", per_a, exp_a_e);
        end
      end
    end
    if (pv_b) begin
      vectors++;
      if (exp_b_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_b: period_valid with period=%0d, no period expected", per_b);
      end else begin
        exp_b_e = exp_b_q.pop_front();
        if (per_b !== exp_b_e) begin
          miscompares++;
          $display("FAIL sb_b: period=%0d expected=%0d", per_b, exp_b_e);
        end
      end
    end
    if (watch_b && st_b) stall_seen_b++;
  end

  // driver: one monitored-clock period starting with a rising edge
  task automatic pulse(input bit sel, input int hi, input int lo);
    if (!sel) begin
      if (armed_a) exp_a_q.push_back(CW_A'(last_a));
      armed_a = 1'b1;
      last_a  = hi + lo;
      mon_a   = 1'b1;
    end else begin
      if (armed_b) exp_b_q.push_back(CW_B'(last_b));
      armed_b = 1'b1;
      last_b  = hi + lo;
      mon_b   = 1'b1;
    end
    repeat (hi) @(negedge clk);
    if (!sel) mon_a = 1'b0; else mon_b = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({per_a, pv_a, lk_a, st_a, ec_a, ht_a, sd_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: per=%0d pv=%b lk=%b st=%b ec=%0d ht=%0d sd=%0d, all zero expected",
               per_a, pv_a, lk_a, st_a, ec_a, ht_a, sd_a);
    end
    vectors++;
    if ({per_b, pv_b, lk_b, st_b, ec_b, ht_b, sd_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: per=%0d pv=%b lk=%b st=%b ec=%0d ht=%0d sd=%0d, all zero expected",
               per_b, pv_b, lk_b, st_b, ec_b, ht_b, sd_b);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 5, 5);
      vectors++;
      if (ec_a !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL lock_edge_cnt[%0d]: got %0d expected %0d", i, ec_a, i + 1);
      end
      vectors++;
      if (lk_a !== (i >= 5)) begin
        miscompares++;
        $display("FAIL lock_locked[%0d]: got %b expected %b", i, lk_a, (i >= 5));
      end
    end
    vectors++;
    if (sd_a !== 2'd2 || per_a !== CW_A'(10) || ht_a !== (HT_EN ? CW_A'(5) : CW_A'(0))) begin
      miscompares++;
      $display("FAIL lock_state: sd=%0d per=%0d ht=%0d expected sd=2 per=10 ht=%0d",
               sd_a, per_a, ht_a, HT_EN ? 5 : 0);
    end
  endtask

  task automatic test_tolerance();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) pulse(1'b0, 7, 7);
      else pulse(1'b0, 5, (i % 2 == 0) ? 6 : 5);
      vectors++;
      if (lk_a !== 1'b1) begin
        miscompares++;
        $display("FAIL tol_locked[%0d]: got %b expected 1", i, lk_a);
      end
    end
    pulse(1'b0, 5, 5);
    vectors++;
    if (lk_a !== 1'b0 || sd_a !== 2'd1) begin
      miscompares++;
      $display("FAIL tol_unlock: lk=%b sd=%0d expected lk=0 sd=1", lk_a, sd_a);
    end
  endtask

  task automatic test_stall();
    int got;
    for (int i = 0; i < 5; i++) pulse(1'b0, 5, 5);
    vectors++;
    if (lk_a !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_relock: got %b expected 1", lk_a);
    end
    if (armed_a) exp_a_q.push_back(CW_A'(last_a));
    mon_a = 1'b1;
    got = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 5) mon_a = 1'b0;
      if (st_a) begin
        got = k;
        break;
      end
    end
    // Rising edge registers 3 clk edges after mon_clk is driven; stall 100 edges later.
    vectors++;
    if (got !== 103) begin
      miscompares++;
      $display("FAIL stall_timing: stall seen after %0d cycles expected 103", got);
    end
    vectors++;
    if (lk_a !== 1'b0 || per_a !== CW_A'(10) || sd_a !== 2'd3) begin
      miscompares++;
      $display("FAIL stall_state: lk=%b per=%0d sd=%0d expected lk=0 per=10 sd=3", lk_a, per_a, sd_a);
    end
    armed_a = 1'b0;
    pulse(1'b0, 5, 5);
    vectors++;
    if (st_a !== 1'b0 || sd_a !== 2'd1) begin
      miscompares++;
      $display("FAIL stall_clear: st=%b sd=%0d expected st=0 sd=1", st_a, sd_a);
    end
  endtask

  task automatic test_reset_mid();
    mon_a = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({per_a, pv_a, lk_a, st_a, ec_a, ht_a, sd_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: per=%0d pv=%b lk=%b st=%b ec=%0d ht=%0d sd=%0d, all zero expected",
               per_a, pv_a, lk_a, st_a, ec_a, ht_a, sd_a);
    end
    exp_a_q.delete();
    exp_b_q.delete();
    armed_a = 1'b0;
    armed_b = 1'b0;
    mon_a = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse(1'b0, 5, 5);
    pulse(1'b0, 5, 5);
    vectors++;
    if (ec_a !== 16'd2 || per_a !== CW_A'(10)) begin
      miscompares++;
      $display("FAIL reset_mid_restart: ec=%0d per=%0d expected ec=2 per=10", ec_a, per_a);
    end
  endtask

  task automatic test_high_time();
    for (int i = 0; i < 3; i++) pulse(1'b0, 3, 7);
    vectors++;
    if (per_a !== CW_A'(10) || ht_a !== (HT_EN ? CW_A'(3) : CW_A'(0))) begin
      miscompares++;
      $display("FAIL high_time: per=%0d ht=%0d expected per=10 ht=%0d", per_a, ht_a, HT_EN ? 3 : 0);
    end
  endtask

  task automatic test_saturation();
    watch_b = 1'b1;
    pulse(1'b1, 6, 6);
    pulse(1'b1, 7, 8);
    pulse(1'b1, 7, 8);
    pulse(1'b1, 6, 6);
    watch_b = 1'b0;
    vectors++;
    if (stall_seen_b !== 0) begin
      miscompares++;
      $display("FAIL sat_no_stall: stall high for %0d cycles expected 0", stall_seen_b);
    end
    pulse(1'b1, 6, 14);
    vectors++;
    if (st_b !== 1'b1 || sd_b !== 2'd3 || per_b !== CW_B'(12)) begin
      miscompares++;
      $display("FAIL sat_stall: st=%b sd=%0d per=%0d expected st=1 sd=3 per=12", st_b, sd_b, per_b);
    end
    armed_b = 1'b0;
    pulse(1'b1, 6, 6);
    pulse(1'b1, 6, 6);
    vectors++;
    if (st_b !== 1'b0 || ec_b !== 16'd7 || lk_b !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_recover: st=%b ec=%0d lk=%b expected st=0 ec=7 lk=0", st_b, ec_b, lk_b);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock();
    test_tolerance();
    test_stall();
    test_reset_mid();
    test_high_time();
    test_saturation();
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: pending a=%0d b=%0d expected 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
